apb_i2c_xfer_ctrl: RTL and testbench
====================================

# apb_i2c_xfer_ctrl

APB master sequencer that sits directly upstream of the APB-to-I2C bridge and drives its APB slave port. It turns a single start request (7-bit device address, direction, byte count) into the full register sequence: release FIFO/I2C resets, program the slave address, push TX bytes or pop RX bytes with status polling, then wait for bus completion. Per-poll timeouts guard every wait.

## Interface
- ADDRESSWIDTH, 4, APB address width
- DATAWIDTH, 8, APB data width
- ADDR_CMD, 4'h0, command register (bit7..4 FIFO reset_n, bit3 I2C reset_n, bit2 enable/repeat-start)
- ADDR_STATUS, 4'h1, status (bit7 tx_full, bit6 tx_empty, bit5 rx_full, bit4 rx_empty, bit3 i2c_ready)
- ADDR_TX, 4'h2, transmit register (write pushes TX FIFO)
- ADDR_RX, 4'h3, receive register (read pops RX FIFO)
- ADDR_SLV, 4'h4, slave address register {addr[6:0], rw}
- TIMEOUT, 1024, max STATUS reads per poll state before error

- PCLK  in  1  clock
- PRESETn  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- dev_addr  in  7  I2C device address, captured on start
- rw  in  1  0 = write, 1 = read; captured on start
- len  in  4  byte count, captured on start; 0 means 16
- wr_data  in  8  next TX byte
- wr_valid / wr_ready  in / out  1  TX byte handshake; transfer when both high
- rd_data  out  8  received byte
- rd_valid  out  1  one-cycle pulse with rd_data
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse, success
- error  out  1  one-cycle pulse, timeout
- PADDR, PWDATA, PWRITE, PSELx, PENABLE  out  4/8/1/1/1  APB master request
- PRDATA, PREADY  in  8/1  APB slave response

## Operation
- Every register access is one APB transfer: SETUP (PSELx=1, PENABLE=0, PADDR/PWRITE/PWDATA valid) for one cycle, then ACCESS (PENABLE=1) held until PREADY=1; PRDATA sampled on that edge. Next transfer may start the following cycle.
- Main FSM: IDLE -> CFG_CMD (write CMD=0xF8) -> CFG_SLV (write SLV={dev_addr,rw}) -> branch.
- Write: GET_BYTE (wr_ready=1 until handshake) -> POLL_TXF (read STATUS until bit7=0) -> WR_TX (write TX). After the first byte only: ENABLE (write CMD=0xFC). Loop until len bytes pushed -> POLL_DONE.
- Read: ENABLE (write CMD=0xFC) -> POLL_RXE (read STATUS until bit4=0) -> RD_RX (read RX; rd_data<=PRDATA, rd_valid pulse). Loop len times -> POLL_DONE.
- POLL_DONE: read STATUS until bit3=1 and (read, or bit6=1) -> DISABLE (write CMD=0xF8) -> done pulse -> IDLE.
- Timeout: poll counter cleared on entry to each POLL_* state, +1 per completed STATUS read; reaching TIMEOUT -> ABORT (write CMD=0x00) -> error pulse -> IDLE. A transfer in ACCESS is never cut short; PREADY held low indefinitely stalls (no timeout on PREADY).
- Byte counter 5 bits, loaded with len (0 -> 16), decremented per TX push / RX pop.

## Timing
- Reset: all outputs 0 (PSELx, PENABLE, PWRITE, PADDR, PWDATA, wr_ready, rd_data, rd_valid, busy, done, error); FSM IDLE; counters 0.
- Reset asserted mid-transfer aborts immediately, APB lines drop same instant; no cleanup write.
- start to first PSELx: 1 cycle. Zero-wait-state access = 2 cycles.
- start while busy is ignored; wr_valid outside GET_BYTE ignored.
- rd_valid asserts the cycle after the RX read's PREADY edge.
- done/error assert the cycle after the final write completes; busy falls with it.

## Test plan
- Write, dev_addr=0x50, len=2, bytes 0xA5,0x3C, PREADY always 1 -> APB writes CMD 0xF8, SLV 0xA0, TX 0xA5, CMD 0xFC, TX 0x3C, then STATUS polls, CMD 0xF8; done pulse once.
- Read, dev_addr=0x50, len=3, RX returns 0x11,0x22,0x33 -> SLV 0xA1, CMD 0xFC, three rd_valid pulses with 0x11,0x22,0x33, done.
- PREADY held low 5 cycles on each access -> PENABLE held, identical sequence, PRDATA captured only on PREADY.
- STATUS tx_full stuck 1, TIMEOUT=8 -> exactly 8 STATUS reads, CMD 0x00 written, error pulse, no done.
- len=0 write -> exactly 16 wr_ready handshakes and 16 TX writes.
- PRESETn low during an ACCESS phase -> all outputs 0 asynchronously; next start runs a clean full sequence.

Source files
------------

// File: rtl/apb_i2c_xfer_ctrl.sv
// rtl/apb_i2c_xfer_ctrl.sv - APB master sequencer driving the APB-to-I2C bridge for one I2C transfer
//
// One start request (dev_addr, rw, len) becomes the full register sequence:
//   CMD=0xF8, SLV={dev_addr,rw}, then TX pushes / RX pops with STATUS polling,
//   a STATUS poll for bus completion, and CMD=0xF8 (done) or CMD=0x00 (error).
// Ports:
//   PCLK, PRESETn                   clock, asynchronous active-low reset
//   start, dev_addr, rw, len        transfer request, captured in IDLE (len 0 = 16 bytes)
//   wr_data, wr_valid, wr_ready     TX byte handshake
//   rd_data, rd_valid               received byte, one-cycle pulse
//   busy, done, error               status; done/error are one-cycle pulses
//   PADDR, PWDATA, PWRITE, PSELx,
//   PENABLE, PRDATA, PREADY         APB master port
module apb_i2c_xfer_ctrl #(
    parameter int                      ADDRESSWIDTH = 4,
    parameter int                      DATAWIDTH    = 8,
    parameter logic [ADDRESSWIDTH-1:0] ADDR_CMD     = 'h0,
    parameter logic [ADDRESSWIDTH-1:0] ADDR_STATUS  = 'h1,
    parameter logic [ADDRESSWIDTH-1:0] ADDR_TX      = 'h2,
    parameter logic [ADDRESSWIDTH-1:0] ADDR_RX      = 'h3,
    parameter logic [ADDRESSWIDTH-1:0] ADDR_SLV     = 'h4,
    parameter int                      TIMEOUT      = 1024
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    start,
    input  logic [6:0]              dev_addr,
    input  logic                    rw,
    input  logic [3:0]              len,
    input  logic [7:0]              wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [DATAWIDTH-1:0]    rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ADDRESSWIDTH-1:0] PADDR,
    output logic [DATAWIDTH-1:0]    PWDATA,
    output logic                    PWRITE,
    output logic                    PSELx,
    output logic                    PENABLE,
    input  logic [DATAWIDTH-1:0]    PRDATA,
    input  logic                    PREADY
);
    localparam int PCW = $clog2(TIMEOUT + 1);
    localparam logic [PCW-1:0] POLL_LAST = PCW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_CMD, S_CFG_SLV, S_GET_BYTE, S_POLL_TXF, S_WR_TX, S_ENABLE,
        S_POLL_RXE, S_RD_RX, S_POLL_DONE, S_DISABLE, S_ABORT
    } state_t;

    state_t                   state, state_d;
    logic                     psel_d, penable_d, pwrite_d;
    logic [ADDRESSWIDTH-1:0]  paddr_d;
    logic [DATAWIDTH-1:0]     pwdata_d, rd_data_d, tx_q, tx_d;
    logic                     rd_valid_d, done_d, error_d, wr_ready_d, busy_d;
    logic [4:0]               byte_cnt, byte_cnt_d;
    logic [PCW-1:0]           poll_cnt, poll_cnt_d;
    logic [6:0]               dev_q, dev_d;
    logic                     rw_q, rw_d, en_q, en_d;
    logic                     xfer_done;

    function automatic logic is_poll(input state_t s);
        return (s == S_POLL_TXF) || (s == S_POLL_RXE) || (s == S_POLL_DONE);
    endfunction

    function automatic logic is_access(input state_t s);
        return (s != S_IDLE) && (s != S_GET_BYTE);
    endfunction

    // An ACCESS phase ends only on PREADY; there is deliberately no bound on it.
    assign xfer_done = PSELx && PENABLE && PREADY;

    always_comb begin
        state_d    = state;
        psel_d     = PSELx;
        penable_d  = PENABLE;
        paddr_d    = PADDR;
        pwrite_d   = PWRITE;
        pwdata_d   = PWDATA;
        rd_data_d  = rd_data;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        byte_cnt_d = byte_cnt;
        poll_cnt_d = poll_cnt;
        dev_d      = dev_q;
        rw_d       = rw_q;
        tx_d       = tx_q;
        en_d       = en_q;

        if (PSELx && !PENABLE) penable_d = 1'b1;
        if (xfer_done) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
        end

        case (state)
            S_IDLE: if (start) begin
                dev_d      = dev_addr;
                rw_d       = rw;
                byte_cnt_d = (len == 4'd0) ? 5'd16 : {1'b0, len};
                en_d       = 1'b0;
                state_d    = S_CFG_CMD;
            end
            S_CFG_CMD: if (xfer_done) state_d = S_CFG_SLV;
            S_CFG_SLV: if (xfer_done) state_d = rw_q ? S_ENABLE : S_GET_BYTE;
            S_GET_BYTE: if (wr_valid && wr_ready) begin
                tx_d    = DATAWIDTH'(wr_data);
                state_d = S_POLL_TXF;
            end
            S_POLL_TXF: if (xfer_done) begin
                poll_cnt_d = poll_cnt + 1'b1;
                if (!PRDATA[7])              state_d = S_WR_TX;
                else if (poll_cnt == POLL_LAST) state_d = S_ABORT;
            end
            S_WR_TX: if (xfer_done) begin
                byte_cnt_d = byte_cnt - 5'd1;
                // The bridge is enabled only once the first byte is queued.
                if (!en_q)                  state_d = S_ENABLE;
                else if (byte_cnt == 5'd1)  state_d = S_POLL_DONE;
                else                        state_d = S_GET_BYTE;
            end
            S_ENABLE: if (xfer_done) begin
                en_d = 1'b1;
                if (rw_q)                   state_d = S_POLL_RXE;
                else if (byte_cnt == 5'd0)  state_d = S_POLL_DONE;
                else                        state_d = S_GET_BYTE;
            end
            S_POLL_RXE: if (xfer_done) begin
                poll_cnt_d = poll_cnt + 1'b1;
                if (!PRDATA[4])              state_d = S_RD_RX;
                else if (poll_cnt == POLL_LAST) state_d = S_ABORT;
            end
            S_RD_RX: if (xfer_done) begin
                rd_data_d  = PRDATA;
                rd_valid_d = 1'b1;
                byte_cnt_d = byte_cnt - 5'd1;
                state_d    = (byte_cnt == 5'd1) ? S_POLL_DONE : S_POLL_RXE;
            end
            S_POLL_DONE: if (xfer_done) begin
                poll_cnt_d = poll_cnt + 1'b1;
                if (PRDATA[3] && (rw_q || PRDATA[6])) state_d = S_DISABLE;
                else if (poll_cnt == POLL_LAST)       state_d = S_ABORT;
            end
            S_DISABLE: if (xfer_done) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_ABORT: if (xfer_done) begin
                error_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (is_poll(state_d) && (state_d != state)) poll_cnt_d = '0;

        // SETUP for the next access is issued on the same edge that enters the
        // state (or that completes the previous read of a repeating poll).
        if (is_access(state_d) && ((state_d != state) || xfer_done)) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = 1'b1;
            pwdata_d  = '0;
            paddr_d   = ADDR_CMD;
            case (state_d)
                S_CFG_CMD, S_DISABLE: pwdata_d = DATAWIDTH'(8'hF8);
                S_ENABLE:             pwdata_d = DATAWIDTH'(8'hFC);
                S_CFG_SLV: begin
                    paddr_d  = ADDR_SLV;
                    pwdata_d = DATAWIDTH'({dev_q, rw_q});
                end
                S_WR_TX: begin
                    paddr_d  = ADDR_TX;
                    pwdata_d = tx_q;
                end
                S_RD_RX: begin
                    paddr_d  = ADDR_RX;
                    pwrite_d = 1'b0;
                end
                S_POLL_TXF, S_POLL_RXE, S_POLL_DONE: begin
                    paddr_d  = ADDR_STATUS;
                    pwrite_d = 1'b0;
                end
                default: pwdata_d = '0;
            endcase
        end

        wr_ready_d = (state_d == S_GET_BYTE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= S_IDLE;
            PSELx    <= 1'b0;
            PENABLE  <= 1'b0;
            PADDR    <= '0;
            PWRITE   <= 1'b0;
            PWDATA   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            wr_ready <= 1'b0;
            busy     <= 1'b0;
            byte_cnt <= '0;
            poll_cnt <= '0;
            dev_q    <= '0;
            rw_q     <= 1'b0;
            tx_q     <= '0;
            en_q     <= 1'b0;
        end else begin
            state    <= state_d;
            PSELx    <= psel_d;
            PENABLE  <= penable_d;
            PADDR    <= paddr_d;
            PWRITE   <= pwrite_d;
            PWDATA   <= pwdata_d;
            rd_data  <= rd_data_d;
            rd_valid <= rd_valid_d;
            done     <= done_d;
            error    <= error_d;
            wr_ready <= wr_ready_d;
            busy     <= busy_d;
            byte_cnt <= byte_cnt_d;
            poll_cnt <= poll_cnt_d;
            dev_q    <= dev_d;
            rw_q     <= rw_d;
            tx_q     <= tx_d;
            en_q     <= en_d;
        end
    end
endmodule

// File: tb/tb_apb_i2c_xfer_ctrl.sv
// tb/tb_apb_i2c_xfer_ctrl.sv - testbench for apb_i2c_xfer_ctrl
module tb_apb_i2c_xfer_ctrl;
    localparam logic [3:0] A_CMD = 4'h0, A_STATUS = 4'h1, A_TX = 4'h2, A_RX = 4'h3, A_SLV = 4'h4;
    localparam int TMO = 8;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b1;
    logic       start = 1'b0;
    logic [6:0] dev_addr = '0;
    logic       rw = 1'b0;
    logic [3:0] len = '0;
    logic [7:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid, busy, done, error;
    logic [3:0] PADDR;
    logic [7:0] PWDATA;
    logic       PWRITE, PSELx, PENABLE;
    logic [7:0] PRDATA = '0;
    logic       PREADY = 1'b0;

    apb_i2c_xfer_ctrl #(.TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .dev_addr(dev_addr), .rw(rw),
        .len(len), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .error(error),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSELx(PSELx), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    typedef struct { logic [3:0] addr; logic wr; logic [7:0] data; } apb_t;
    typedef struct {
        logic rw; logic [6:0] dev; logic [3:0] len; int waits; bit stuck; int hold;
        logic [7:0] seed; logic [7:0] step; int x_done; int x_err; int x_hs; int x_rx;
    } vec_t;

    apb_t       exp_q[$];
    logic [7:0] rx_src[$];
    logic [7:0] rx_exp[$];
    logic [7:0] tx_bytes[16];
    int  tx_n = 0, tx_idx = 0, waits = 0, acc_cnt = 0;
    bit  hs_pending = 0, stuck = 0;
    int  hs_cnt = 0, done_cnt = 0, err_cnt = 0, rdv_cnt = 0;
    int  total = 0, bad = 0;
    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic exp_push(input logic [3:0] a, input logic w, input logic [7:0] d);
        apb_t e;
        e.addr = a; e.wr = w; e.data = d;
        exp_q.push_back(e);
    endtask

    // Slave model, APB monitor/scoreboard, TX source and output counters.
    initial forever begin
        apb_t e;
        @(negedge PCLK);
        if (PSELx && PENABLE) acc_cnt++; else acc_cnt = 0;
        PREADY = PSELx && PENABLE && (acc_cnt > waits);
        case (PADDR)
            A_STATUS: PRDATA = {stuck, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000};
            A_RX:     PRDATA = (rx_src.size() > 0) ? rx_src[0] : 8'h00;
            default:  PRDATA = 8'h00;
        endcase
        if (PREADY) begin
            if (exp_q.size() == 0) begin
                check("apb_extra_xfer", {PADDR, 3'b0, PWRITE, PWDATA}, 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("apb_addr", PADDR, e.addr);
                check("apb_dir", PWRITE, e.wr);
                if (e.wr) check("apb_wdata", PWDATA, e.data);
            end
            if (PADDR == A_RX && !PWRITE && rx_src.size() > 0) void'(rx_src.pop_front());
        end
        if (hs_pending) begin tx_idx++; hs_pending = 0; end
        wr_valid = (tx_idx < tx_n);
        wr_data  = wr_valid ? tx_bytes[tx_idx[3:0]] : 8'h00;
        if (wr_valid && wr_ready) begin hs_pending = 1; hs_cnt++; end
        if (rd_valid) begin
            rdv_cnt++;
            if (rx_exp.size() == 0) check("rd_extra", rd_data, 32'h1FF);
            else check("rd_data", rd_data, rx_exp.pop_front());
        end
        if (done) done_cnt++;
        if (error) err_cnt++;
    end

    task automatic prep(input vec_t v);
        int n;
        logic [7:0] b;
        n = (v.len == 4'd0) ? 16 : int'(v.len);
        waits = v.waits; stuck = v.stuck;
        exp_q.delete(); rx_src.delete(); rx_exp.delete();
        hs_cnt = 0; done_cnt = 0; err_cnt = 0; rdv_cnt = 0;
        tx_idx = 0; hs_pending = 0; tx_n = 0;
        exp_push(A_CMD, 1'b1, 8'hF8);
        exp_push(A_SLV, 1'b1, {v.dev, v.rw});
        b = v.seed;
        if (!v.rw) begin
            for (int i = 0; i < n; i++) begin tx_bytes[i] = b; b = b + v.step; end
            tx_n = n;
            if (v.stuck) begin
                for (int i = 0; i < TMO; i++) exp_push(A_STATUS, 1'b0, 8'h00);
                exp_push(A_CMD, 1'b1, 8'h00);
            end else begin
                for (int i = 0; i < n; i++) begin
                    exp_push(A_STATUS, 1'b0, 8'h00);
                    exp_push(A_TX, 1'b1, tx_bytes[i]);
                    if (i == 0) exp_push(A_CMD, 1'b1, 8'hFC);
                end
                exp_push(A_STATUS, 1'b0, 8'h00);
                exp_push(A_CMD, 1'b1, 8'hF8);
            end
        end else begin
            exp_push(A_CMD, 1'b1, 8'hFC);
            for (int i = 0; i < n; i++) begin
                exp_push(A_STATUS, 1'b0, 8'h00);
                exp_push(A_RX, 1'b0, 8'h00);
                rx_src.push_back(b); rx_exp.push_back(b);
                b = b + v.step;
            end
            exp_push(A_STATUS, 1'b0, 8'h00);
            exp_push(A_CMD, 1'b1, 8'hF8);
        end
    endtask

    task automatic kick(input vec_t v);
        @(negedge PCLK);
        start = 1'b1; dev_addr = v.dev; rw = v.rw; len = v.len;
        @(negedge PCLK);
        check("start_to_psel", {PSELx, PENABLE, busy}, 3'b101);
        repeat (v.hold - 1) @(negedge PCLK);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        prep(v);
        kick(v);
        for (int c = 0; c < 4000 && (done_cnt + err_cnt) == 0; c++) @(negedge PCLK);
        check({nm, "_finished"}, ((done_cnt + err_cnt) != 0), 1);
        check({nm, "_busy_low"}, busy, 0);
        repeat (12) @(negedge PCLK);
        check({nm, "_done_cnt"}, done_cnt, v.x_done);
        check({nm, "_err_cnt"}, err_cnt, v.x_err);
        check({nm, "_wr_handshakes"}, hs_cnt, v.x_hs);
        check({nm, "_rd_pulses"}, rdv_cnt, v.x_rx);
        check({nm, "_apb_left"}, exp_q.size(), 0);
        check({nm, "_rx_left"}, rx_exp.size(), 0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_psel"}, PSELx, 0);
        check({nm, "_penable"}, PENABLE, 0);
        check({nm, "_pwrite"}, PWRITE, 0);
        check({nm, "_paddr"}, PADDR, 0);
        check({nm, "_pwdata"}, PWDATA, 0);
        check({nm, "_wr_ready"}, wr_ready, 0);
        check({nm, "_rd_data"}, rd_data, 0);
        check({nm, "_rd_valid"}, rd_valid, 0);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_done"}, done, 0);
        check({nm, "_error"}, error, 0);
    endtask

    initial begin
        vec_t rv;
        //          rw  dev    len  waits stuck hold seed   step   done err hs rx
        vecs[0] = '{1'b0, 7'h50, 4'd2, 0, 1'b0, 1, 8'hA5, 8'h97, 1, 0, 2, 0};
        vecs[1] = '{1'b1, 7'h50, 4'd3, 0, 1'b0, 1, 8'h11, 8'h11, 1, 0, 0, 3};
        vecs[2] = '{1'b0, 7'h50, 4'd2, 5, 1'b0, 1, 8'hA5, 8'h97, 1, 0, 2, 0};
        vecs[3] = '{1'b1, 7'h50, 4'd3, 5, 1'b0, 1, 8'h11, 8'h11, 1, 0, 0, 3};
        vecs[4] = '{1'b0, 7'h2A, 4'd2, 0, 1'b1, 1, 8'h5A, 8'h01, 0, 1, 1, 0};
        vecs[5] = '{1'b0, 7'h13, 4'd0, 0, 1'b0, 1, 8'h01, 8'h0B, 1, 0, 16, 0};
        vecs[6] = '{1'b1, 7'h7F, 4'd1, 1, 1'b0, 3, 8'hC3, 8'h01, 1, 0, 0, 1};
        vecs[7] = '{1'b1, 7'h05, 4'd0, 0, 1'b0, 1, 8'hF0, 8'h07, 1, 0, 0, 16};

        #1 PRESETn = 1'b0;
        repeat (3) @(negedge PCLK);
        check_all_zero("reset");
        PRESETn = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of an ACCESS phase, then a clean rerun.
        rv = vecs[0];
        rv.waits = 3;
        prep(rv);
        kick(rv);
        for (int c = 0; c < 200 && !(PSELx && PENABLE && PADDR == A_SLV); c++) @(negedge PCLK);
        check("rst_reached_access", {PSELx, PENABLE, PADDR}, {2'b11, A_SLV});
        #2 PRESETn = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge PCLK);
        exp_q.delete(); rx_src.delete(); rx_exp.delete(); tx_n = 0; tx_idx = 0; hs_pending = 0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        run_vec(vecs[0], "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
